hazard_stall_unit: RTL and testbench

Pipeline interlock for the 5-stage processor: detects load-use hazards between the F/D and D/X latches and sequences the multiply/divide unit, producing one global stall. It replaces the ad-hoc combinational stall logic with a clocked multdiv state machine, source-usage decode so that only registers actually read cause stalls, r0 filtering, and parametrised field widths. It sits beside the decode stage, and its `stall` output gates the PC, F/D and D/X latch enables.

---
 rtl/proc_isa_pkg.sv | 29 ++
 rtl/src_use_decode.sv | 35 +++
 rtl/hazard_stall_unit.sv | 128 ++++++++++++
 tb/tb_hazard_stall_unit.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/proc_isa_pkg.sv
// Shared ISA definitions for the 5-stage pipeline: opcodes, ALU ops, field positions
// and the multdiv sequencer state type.
package proc_isa_pkg;

  localparam int OPC_W     = 5;
  localparam int ALUOP_W   = 5;
  localparam int OPC_LSB   = 27;
  localparam int RD_LSB    = 22;
  localparam int RS_LSB    = 17;
  localparam int RT_LSB    = 12;
  localparam int ALUOP_LSB = 2;

  localparam logic [OPC_W-1:0] OP_R    = 5'b00000;
  localparam logic [OPC_W-1:0] OP_ADDI = 5'b00101;
  localparam logic [OPC_W-1:0] OP_LW   = 5'b01000;
  localparam logic [OPC_W-1:0] OP_SW   = 5'b00111;
  localparam logic [OPC_W-1:0] OP_BNE  = 5'b00010;
  localparam logic [OPC_W-1:0] OP_BLT  = 5'b00110;
  localparam logic [OPC_W-1:0] OP_JR   = 5'b00100;

  localparam logic [ALUOP_W-1:0] ALU_MUL = 5'b00110;
  localparam logic [ALUOP_W-1:0] ALU_DIV = 5'b00111;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_t;

endpackage

// File: rtl/src_use_decode.sv
// Opcode to source-register usage flags; shared by the interlock and the bypass muxes.
module src_use_decode
  import proc_isa_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  output logic             uses_rd,
  output logic             uses_rs,
  output logic             uses_rt
);

  always_comb begin
    uses_rd = 1'b0;
    uses_rs = 1'b0;
    uses_rt = 1'b0;
    case (opcode)
      OP_R: begin
        uses_rs = 1'b1;
        uses_rt = 1'b1;
      end
      OP_ADDI, OP_LW: begin
        uses_rs = 1'b1;
      end
      // Stores and branches read the rd field as a data/compare source.
      OP_SW, OP_BNE, OP_BLT: begin
        uses_rd = 1'b1;
        uses_rs = 1'b1;
      end
      OP_JR: begin
        uses_rd = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// Load-use interlock and multdiv sequencer producing the global pipeline stall.
// Optional saturating stall counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_stall_unit
  import proc_isa_pkg::*;
#(
  parameter int INSN_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [INSN_W-1:0] fd_insn,
  input  logic [INSN_W-1:0] dx_insn,
  input  logic              multdiv_ready,
  output logic              multdiv_start,
  output logic              md_is_div,
  output logic              stall,
  output logic [CNT_W-1:0]  load_stall_cnt,
  output logic [CNT_W-1:0]  md_stall_cnt
);

  logic [OPC_W-1:0]   fd_opcode;
  logic [OPC_W-1:0]   dx_opcode;
  logic [ALUOP_W-1:0] dx_aluop;
  logic [REG_W-1:0]   dx_rd;
  logic [2:0][REG_W-1:0] fd_src;
  logic [2:0]         fd_use;
  logic [2:0]         src_match;
  logic               load_hz;
  logic               dx_md;
  logic               md_stall;
  md_state_t          state_reg;
  md_state_t          state_next;

  assign fd_opcode = fd_insn[OPC_LSB +: OPC_W];
  assign dx_opcode = dx_insn[OPC_LSB +: OPC_W];
  assign dx_aluop  = dx_insn[ALUOP_LSB +: ALUOP_W];
  assign dx_rd     = dx_insn[RD_LSB +: REG_W];
  assign fd_src[0] = fd_insn[RD_LSB +: REG_W];
  assign fd_src[1] = fd_insn[RS_LSB +: REG_W];
  assign fd_src[2] = fd_insn[RT_LSB +: REG_W];

  logic unused_insn_bits;
  assign unused_insn_bits = ^{fd_insn[RT_LSB-1:0],
                              dx_insn[RD_LSB-1:ALUOP_LSB+ALUOP_W],
                              dx_insn[ALUOP_LSB-1:0]};

  src_use_decode u_src_use_decode (
    .opcode  (fd_opcode),
    .uses_rd (fd_use[0]),
    .uses_rs (fd_use[1]),
    .uses_rt (fd_use[2])
  );

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_src_cmp
      assign src_match[gi] = fd_use[gi] && (fd_src[gi] == dx_rd);
    end
  endgenerate

  // r0 is hardwired, so a load targeting it can never create a dependency.
  assign load_hz = (dx_opcode == OP_LW) && (dx_rd != '0) && (|src_match);
  assign dx_md   = (dx_opcode == OP_R) &&
                   ((dx_aluop == ALU_MUL) || (dx_aluop == ALU_DIV));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    multdiv_start = 1'b0;
    md_is_div     = 1'b0;
    md_stall      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (dx_md) begin
          multdiv_start = 1'b1;
          md_is_div     = dx_aluop[0];
          md_stall      = 1'b1;
          state_next    = BUSY;
        end
      end
      BUSY: begin
        // The op stays in D/X until ready; the ready cycle itself lets it advance.
        if (multdiv_ready) begin
          state_next = IDLE;
        end else begin
          md_stall = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign stall = load_hz | md_stall;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] load_cnt_reg;
  logic [CNT_W-1:0] md_cnt_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      load_cnt_reg <= '0;
      md_cnt_reg   <= '0;
    end else begin
      if (load_hz && (load_cnt_reg != '1)) begin
        load_cnt_reg <= load_cnt_reg + 1'b1;
      end
      if (md_stall && (md_cnt_reg != '1)) begin
        md_cnt_reg <= md_cnt_reg + 1'b1;
      end
    end
  end

  assign load_stall_cnt = load_cnt_reg;
  assign md_stall_cnt   = md_cnt_reg;
`else
  assign load_stall_cnt = '0;
  assign md_stall_cnt   = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed self-checking bench for hazard_stall_unit: load-use cases, mul/div
// sequencing, spurious ready, reset during BUSY and (when enabled) stall counters.
module tb_hazard_stall_unit;

  logic        clock;
  logic        reset_n;
  logic [31:0] fd_insn;
  logic [31:0] dx_insn;
  logic        multdiv_ready;
  logic        multdiv_start;
  logic        md_is_div;
  logic        stall;
  logic [15:0] load_stall_cnt;
  logic [15:0] md_stall_cnt;

  int tests_run;
  int tests_failed;

  hazard_stall_unit #(
    .INSN_W (32),
    .REG_W  (5),
    .CNT_W  (16)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .fd_insn        (fd_insn),
    .dx_insn        (dx_insn),
    .multdiv_ready  (multdiv_ready),
    .multdiv_start  (multdiv_start),
    .md_is_div      (md_is_div),
    .stall          (stall),
    .load_stall_cnt (load_stall_cnt),
    .md_stall_cnt   (md_stall_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [4:0] alu);
    return {op, rd, rs, rt, 5'b00000, alu, 2'b00};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  localparam logic [31:0] BUBBLE = 32'h0;
  logic [31:0] add_r3_r1_r2, lw_r2, lw_r0, lw_r6, lw_r5, addi_r4, sw_r6, jr_r5, mul_op, div_op;
  logic [31:0] exp_load_cnt, exp_md_cnt;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    add_r3_r1_r2 = mk(5'b00000, 5'd3, 5'd1, 5'd2, 5'b00000);
    lw_r2        = mk(5'b01000, 5'd2, 5'd0, 5'd0, 5'b00000);
    lw_r0        = mk(5'b01000, 5'd0, 5'd0, 5'd0, 5'b00000);
    lw_r6        = mk(5'b01000, 5'd6, 5'd0, 5'd0, 5'b00000);
    lw_r5        = mk(5'b01000, 5'd5, 5'd0, 5'd0, 5'b00000);
    addi_r4      = mk(5'b00101, 5'd4, 5'd5, 5'd2, 5'b00000) | 32'd7;
    sw_r6        = mk(5'b00111, 5'd6, 5'd1, 5'd0, 5'b00000);
    jr_r5        = mk(5'b00100, 5'd5, 5'd0, 5'd0, 5'b00000);
    mul_op       = mk(5'b00000, 5'd7, 5'd1, 5'd2, 5'b00110);
    div_op       = mk(5'b00000, 5'd8, 5'd3, 5'd4, 5'b00111);

    reset_n       = 1'b0;
    fd_insn       = BUBBLE;
    dx_insn       = BUBBLE;
    multdiv_ready = 1'b0;
    #12;
    chk("reset_stall", stall, 0);
    chk("reset_start", multdiv_start, 0);
    chk("reset_load_cnt", load_stall_cnt, 0);
    chk("reset_md_cnt", md_stall_cnt, 0);

    next_cycle(); reset_n = 1'b1;
    sample(); chk("idle_bubble_stall", stall, 0);

    // Load-use: add r3,r1,r2 behind lw r2
    next_cycle(); fd_insn = add_r3_r1_r2; dx_insn = lw_r2;
    sample(); chk("lw_rt_stall", stall, 1);
    next_cycle(); dx_insn = BUBBLE;
    sample(); chk("lw_rt_release", stall, 0);
    next_cycle(); dx_insn = lw_r0;
    sample(); chk("lw_r0_no_stall", stall, 0);
    next_cycle(); fd_insn = addi_r4; dx_insn = lw_r2;
    sample(); chk("addi_rt_unused", stall, 0);
    next_cycle(); fd_insn = sw_r6; dx_insn = lw_r6;
    sample(); chk("sw_rd_stall", stall, 1);
    next_cycle(); fd_insn = jr_r5; dx_insn = lw_r5;
    sample(); chk("jr_rd_stall", stall, 1);
    next_cycle(); fd_insn = jr_r5; dx_insn = lw_r6;
    sample(); chk("jr_other_reg", stall, 0);
    next_cycle(); fd_insn = BUBBLE; dx_insn = BUBBLE;
`ifdef HAZARD_PERF_CNT_EN
    exp_load_cnt = 32'd3;
`else
    exp_load_cnt = 32'd0;
`endif
    sample(); chk("load_cnt_after_lw", load_stall_cnt, exp_load_cnt);

    // mul with ready 5 cycles after start
    next_cycle(); dx_insn = mul_op;
    sample();
    chk("mul_start", multdiv_start, 1);
    chk("mul_is_div", md_is_div, 0);
    chk("mul_stall_c0", stall, 1);
    for (int c = 1; c < 5; c++) begin
      next_cycle();
      sample();
      chk($sformatf("mul_busy_start_c%0d", c), multdiv_start, 0);
      chk($sformatf("mul_busy_stall_c%0d", c), stall, 1);
    end
    next_cycle(); multdiv_ready = 1'b1;
    sample(); chk("mul_ready_stall", stall, 0);
    chk("mul_ready_start", multdiv_start, 0);
    next_cycle(); multdiv_ready = 1'b0; dx_insn = BUBBLE;
    sample(); chk("mul_after_idle_stall", stall, 0);
`ifdef HAZARD_PERF_CNT_EN
    exp_md_cnt = 32'd5;
`else
    exp_md_cnt = 32'd0;
`endif
    chk("md_cnt_after_mul", md_stall_cnt, exp_md_cnt);

    // Two back-to-back divs, then a spurious ready while idle
    next_cycle(); dx_insn = div_op;
    sample(); chk("div1_start", multdiv_start, 1);
    chk("div1_is_div", md_is_div, 1);
    chk("div1_stall", stall, 1);
    next_cycle();
    sample(); chk("div1_no_restart", multdiv_start, 0);
    chk("div1_busy_stall", stall, 1);
    next_cycle(); multdiv_ready = 1'b1;
    sample(); chk("div1_ready_stall", stall, 0);
    next_cycle(); multdiv_ready = 1'b0;
    sample(); chk("div2_start", multdiv_start, 1);
    chk("div2_is_div", md_is_div, 1);
    chk("div2_stall", stall, 1);
    next_cycle(); multdiv_ready = 1'b1;
    sample(); chk("div2_ready_stall", stall, 0);
    chk("div2_ready_start", multdiv_start, 0);
    next_cycle(); dx_insn = BUBBLE; multdiv_ready = 1'b1;
    sample(); chk("spurious_ready_stall", stall, 0);
    chk("spurious_ready_start", multdiv_start, 0);
    next_cycle(); multdiv_ready = 1'b0;
    sample(); chk("idle_after_spurious", stall, 0);

    // Reset while BUSY
    next_cycle(); dx_insn = mul_op;
    sample(); chk("rst_mul_start", multdiv_start, 1);
    next_cycle();
    sample(); chk("rst_mul_busy", stall, 1);
    #2; reset_n = 1'b0; dx_insn = BUBBLE;
    #1; chk("rst_busy_stall", stall, 0);
    chk("rst_busy_start", multdiv_start, 0);
    chk("rst_load_cnt", load_stall_cnt, 0);
    chk("rst_md_cnt", md_stall_cnt, 0);
    next_cycle(); reset_n = 1'b1; dx_insn = mul_op;
    sample(); chk("post_rst_idle_start", multdiv_start, 1);
    next_cycle(); multdiv_ready = 1'b1;
    sample(); chk("post_rst_ready_stall", stall, 0);
    next_cycle(); multdiv_ready = 1'b0; dx_insn = BUBBLE;
    sample(); chk("final_idle_stall", stall, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
